vga_timing_gen: RTL and testbench

- Generates the raster scan that drives the pixel renderer: horizontal and vertical counters, sync pulses, and the active-video enable.
- Outputs XPOS, YPOS and DISP_EN, which the display block consumes to colour each pixel.
- Also outputs HSYNC/VSYNC to the VGA connector, and FRAME_START/LINE_START strobes for game logic (paddle/ball position updates once per frame).
- Default timing is 640x480 @ 60 Hz.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters and registered,
// mutually aligned position, blanking, sync and start-of-line/frame outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIX_DIV   = 1
) (
    input  logic        VGA_CLOCK,
    input  logic        RESET,
    output logic        PIX_EN,
    output logic [31:0] XPOS,
    output logic [31:0] YPOS,
    output logic        DISP_EN,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        LINE_START,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
    localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   hcount_q, hcount_d;
    logic [V_W-1:0]   vcount_q, vcount_d;
    logic             pix_en_q, pix_en_d;
    logic [31:0]      xpos_q, xpos_d;
    logic [31:0]      ypos_q, ypos_d;
    logic             disp_en_q, disp_en_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic [31:0]      h_ext, v_ext;

    assign tick  = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_ext = 32'(hcount_q);
    assign v_ext = 32'(vcount_q);

    always_comb begin
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        pix_en_d      = tick;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        disp_en_d     = disp_en_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        // Outputs describe the pixel the counters point at before they advance,
        // so the first tick after reset presents pixel (0,0).
        if (tick) begin
            xpos_d        = h_ext;
            ypos_d        = v_ext;
            disp_en_d     = (h_ext < H_ACT) && (v_ext < V_ACT);
            hsync_d       = (h_ext >= HS_BEG && h_ext < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (v_ext >= VS_BEG && v_ext < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (hcount_q == '0);
            frame_start_d = (hcount_q == '0) && (vcount_q == '0);

            if (hcount_q == H_W'(H_TOTAL - 1)) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_W'(V_TOTAL - 1)) ? '0 : vcount_q + V_W'(1);
            end else begin
                hcount_d = hcount_q + H_W'(1);
            end
        end
    end

    always_ff @(posedge VGA_CLOCK) begin
        if (RESET) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pix_en_q      <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            disp_en_q     <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_en_q      <= pix_en_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            disp_en_q     <= disp_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_EN      = pix_en_q;
    assign XPOS        = xpos_q;
    assign YPOS        = ypos_q;
    assign DISP_EN     = disp_en_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a small raster,
// and a small raster with PIX_DIV=2 and active-high syncs) against a cycle-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pix_en;
        logic [31:0] x;
        logic [31:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def = 1'b1, rst_sm = 1'b1, rst_d2 = 1'b1;
    int   k_def = 0, k_sm = 0, k_d2 = 0;
    int   checks = 0, errors = 0;

    logic        pe_def, de_def, hs_def, vs_def, ls_def, fs_def;
    logic [31:0] x_def, y_def;
    logic        pe_sm, de_sm, hs_sm, vs_sm, ls_sm, fs_sm;
    logic [31:0] x_sm, y_sm;
    logic        pe_d2, de_d2, hs_d2, vs_d2, ls_d2, fs_d2;
    logic [31:0] x_d2, y_d2;
    obs_t act_def, act_sm, act_d2;

    assign act_def = {pe_def, x_def, y_def, de_def, hs_def, vs_def, ls_def, fs_def};
    assign act_sm  = {pe_sm, x_sm, y_sm, de_sm, hs_sm, vs_sm, ls_sm, fs_sm};
    assign act_d2  = {pe_d2, x_d2, y_d2, de_d2, hs_d2, vs_d2, ls_d2, fs_d2};

    vga_timing_gen u_def (
        .VGA_CLOCK(clk), .RESET(rst_def), .PIX_EN(pe_def), .XPOS(x_def), .YPOS(y_def),
        .DISP_EN(de_def), .HSYNC(hs_def), .VSYNC(vs_def), .LINE_START(ls_def), .FRAME_START(fs_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_sm (
        .VGA_CLOCK(clk), .RESET(rst_sm), .PIX_EN(pe_sm), .XPOS(x_sm), .YPOS(y_sm),
        .DISP_EN(de_sm), .HSYNC(hs_sm), .VSYNC(vs_sm), .LINE_START(ls_sm), .FRAME_START(fs_sm)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(2)
    ) u_d2 (
        .VGA_CLOCK(clk), .RESET(rst_d2), .PIX_EN(pe_d2), .XPOS(x_d2), .YPOS(y_d2),
        .DISP_EN(de_d2), .HSYNC(hs_d2), .VSYNC(vs_d2), .LINE_START(ls_d2), .FRAME_START(fs_d2)
    );

    // k = number of non-reset clock edges since the last reset edge.
    // Pixel p is presented from edge (p+1)*div onward; raster position is p mod frame.
    function automatic obs_t model(input int k, input int div,
                                   input int ha, input int hfp, input int hs, input int hbp,
                                   input int va, input int vfp, input int vs, input int vbp,
                                   input bit hp, input bit vp);
        obs_t o;
        int ht, vt, p, x, y;
        o    = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        if (k >= div) begin
            ht = ha + hfp + hs + hbp;
            vt = va + vfp + vs + vbp;
            p  = (k - div) / div;
            x  = p % ht;
            y  = (p / ht) % vt;
            o.pix_en = (k % div) == 0;
            o.x  = 32'(x);
            o.y  = 32'(y);
            o.de = (x < ha) && (y < va);
            o.hs = (x >= ha + hfp && x < ha + hfp + hs) ? hp : ~hp;
            o.vs = (y >= va + vfp && y < va + vfp + vs) ? vp : ~vp;
            o.ls = (x == 0);
            o.fs = (x == 0) && (y == 0);
        end
        return o;
    endfunction

    function automatic obs_t exp_def(input int k);
        return model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction
    function automatic obs_t exp_sm(input int k);
        return model(k, 1, 16, 2, 3, 4, 6, 1, 2, 2, 1'b0, 1'b0);
    endfunction
    function automatic obs_t exp_d2(input int k);
        return model(k, 2, 16, 2, 3, 4, 6, 1, 2, 2, 1'b1, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        k_def = rst_def ? 0 : k_def + 1;
        k_sm  = rst_sm  ? 0 : k_sm + 1;
        k_d2  = rst_d2  ? 0 : k_d2 + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_def = 1'b1; rst_sm = 1'b1; rst_d2 = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (act_def !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++; $display("FAIL reset_def got=%h expected=%h", act_def, exp_def(0));
            end
            checks++;
            if (act_d2 !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL reset_d2 got=%h expected=%h", act_d2, exp_d2(0));
            end
        end
        rst_def = 1'b0; rst_sm = 1'b0; rst_d2 = 1'b0;
        tick();
        checks++;
        if (!(x_def === 0 && y_def === 0 && de_def === 1'b1 && fs_def === 1'b1 && ls_def === 1'b1)) begin
            errors++; $display("FAIL first_pixel_def got x=%0d y=%0d de=%b fs=%b ls=%b expected 0 0 1 1 1",
                               x_def, y_def, de_def, fs_def, ls_def);
        end
        checks++;
        if (act_sm !== exp_sm(k_sm)) begin
            errors++; $display("FAIL first_pixel_sm got=%h expected=%h", act_sm, exp_sm(k_sm));
        end
        checks++;
        if (act_d2 !== exp_d2(k_d2)) begin
            errors++; $display("FAIL first_cycle_d2 got=%h expected=%h", act_d2, exp_d2(k_d2));
        end
    endtask

    task automatic test_line();
        int de_cnt = 0, hs_cnt = 0;
        int ls_k[$];
        for (int i = 0; i < 1600; i++) begin
            tick();
            checks++;
            if (act_def !== exp_def(k_def)) begin
                errors++; $display("FAIL line_def k=%0d got=%h expected=%h", k_def, act_def, exp_def(k_def));
            end
            if (i < 800) begin
                if (de_def) de_cnt++;
                if (!hs_def) hs_cnt++;
            end
            if (ls_def) ls_k.push_back(k_def);
        end
        checks++;
        if (de_cnt != 640) begin errors++; $display("FAIL line_de_count got=%0d expected=640", de_cnt); end
        checks++;
        if (hs_cnt != 96) begin errors++; $display("FAIL line_hsync_count got=%0d expected=96", hs_cnt); end
        checks++;
        if (ls_k.size() != 2 || ls_k[1] - ls_k[0] != 800) begin
            errors++; $display("FAIL line_start_period got_count=%0d expected 2 strobes 800 apart", ls_k.size());
        end
    endtask

    task automatic test_frame();
        int fs_k[$];
        int max_x = 0, max_y = 0, bad_de = 0, vs_cnt = 0, de_cnt = 0;
        for (int i = 0; i < 3 * 275; i++) begin
            tick();
            checks++;
            if (act_sm !== exp_sm(k_sm)) begin
                errors++; $display("FAIL frame_sm k=%0d got=%h expected=%h", k_sm, act_sm, exp_sm(k_sm));
            end
            if (int'(x_sm) > max_x) max_x = int'(x_sm);
            if (int'(y_sm) > max_y) max_y = int'(y_sm);
            if (de_sm && y_sm >= 6) bad_de++;
            if (de_sm) de_cnt++;
            if (!vs_sm) vs_cnt++;
            if (fs_sm) fs_k.push_back(k_sm);
        end
        checks++;
        if (max_x != 24 || max_y != 10) begin
            errors++; $display("FAIL frame_max got x=%0d y=%0d expected 24 10", max_x, max_y);
        end
        checks++;
        if (bad_de != 0 || de_cnt != 288) begin
            errors++; $display("FAIL frame_de got bad=%0d count=%0d expected 0 288", bad_de, de_cnt);
        end
        checks++;
        if (vs_cnt != 150) begin errors++; $display("FAIL frame_vsync_count got=%0d expected=150", vs_cnt); end
        checks++;
        if (fs_k.size() != 3 || fs_k[1] - fs_k[0] != 275 || fs_k[2] - fs_k[1] != 275) begin
            errors++; $display("FAIL frame_start_period got_count=%0d expected 3 strobes 275 apart", fs_k.size());
        end
    endtask

    task automatic test_pix_div2();
        int fs_k[$];
        int bad_toggle = 0, bad_hold = 0;
        logic pe_prev;
        logic [31:0] x_prev;
        pe_prev = pe_d2;
        x_prev  = x_d2;
        for (int i = 0; i < 1200; i++) begin
            tick();
            checks++;
            if (act_d2 !== exp_d2(k_d2)) begin
                errors++; $display("FAIL pixdiv2 k=%0d got=%h expected=%h", k_d2, act_d2, exp_d2(k_d2));
            end
            if (pe_d2 === pe_prev) bad_toggle++;
            if (!pe_d2 && x_d2 !== x_prev) bad_hold++;
            if (fs_d2 && pe_d2) fs_k.push_back(k_d2);
            pe_prev = pe_d2;
            x_prev  = x_d2;
        end
        checks++;
        if (bad_toggle != 0 || bad_hold != 0) begin
            errors++; $display("FAIL pixdiv2_cadence got toggle_err=%0d hold_err=%0d expected 0 0", bad_toggle, bad_hold);
        end
        checks++;
        if (fs_k.size() < 2 || fs_k[1] - fs_k[0] != 550) begin
            errors++; $display("FAIL pixdiv2_frame_period got_count=%0d expected strobes 550 apart", fs_k.size());
        end
    endtask

    // Park the small raster inside both sync windows, then pulse reset for one edge.
    task automatic test_mid_reset();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (x_sm >= 18 && x_sm <= 20 && y_sm >= 7 && y_sm <= 8) found = 1;
        end
        checks++;
        if (!found || hs_sm !== 1'b0 || vs_sm !== 1'b0) begin
            errors++; $display("FAIL mid_reset_setup got found=%0d hs=%b vs=%b expected 1 0 0", found, hs_sm, vs_sm);
        end
        rst_sm = 1'b1;
        tick();
        rst_sm = 1'b0;
        checks++;
        if (!(hs_sm === 1'b1 && vs_sm === 1'b1 && x_sm === 0 && y_sm === 0 && fs_sm === 1'b0)) begin
            errors++; $display("FAIL mid_reset_sm got hs=%b vs=%b x=%0d y=%0d fs=%b expected 1 1 0 0 0",
                               hs_sm, vs_sm, x_sm, y_sm, fs_sm);
        end
        tick();
        checks++;
        if (!(fs_sm === 1'b1 && ls_sm === 1'b1 && x_sm === 0 && y_sm === 0 && de_sm === 1'b1)) begin
            errors++; $display("FAIL mid_reset_restart got fs=%b ls=%b x=%0d y=%0d de=%b expected 1 1 0 0 1",
                               fs_sm, ls_sm, x_sm, y_sm, de_sm);
        end
    endtask

    task automatic test_polarity();
        bit found = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (x_d2 >= 18 && x_d2 <= 20 && y_d2 >= 7 && y_d2 <= 8) found = 1;
        end
        checks++;
        if (!found || hs_d2 !== 1'b1 || vs_d2 !== 1'b1) begin
            errors++; $display("FAIL polarity_active got found=%0d hs=%b vs=%b expected 1 1 1", found, hs_d2, vs_d2);
        end
        rst_d2 = 1'b1;
        tick();
        rst_d2 = 1'b0;
        checks++;
        if (hs_d2 !== 1'b0 || vs_d2 !== 1'b0 || pe_d2 !== 1'b0) begin
            errors++; $display("FAIL polarity_reset got hs=%b vs=%b pe=%b expected 0 0 0", hs_d2, vs_d2, pe_d2);
        end
    endtask

    task automatic test_random_reset();
        int rem_sm = 0, rem_d2 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rem_sm == 0 && $urandom_range(63) == 0) rem_sm = $urandom_range(3, 1);
            if (rem_d2 == 0 && $urandom_range(63) == 0) rem_d2 = $urandom_range(3, 1);
            rst_sm = (rem_sm != 0);
            rst_d2 = (rem_d2 != 0);
            if (rem_sm != 0) rem_sm--;
            if (rem_d2 != 0) rem_d2--;
            tick();
            checks++;
            if (act_sm !== exp_sm(k_sm)) begin
                errors++; $display("FAIL rand_sm k=%0d got=%h expected=%h", k_sm, act_sm, exp_sm(k_sm));
            end
            checks++;
            if (act_d2 !== exp_d2(k_d2)) begin
                errors++; $display("FAIL rand_d2 k=%0d got=%h expected=%h", k_d2, act_d2, exp_d2(k_d2));
            end
        end
        rst_sm = 1'b0;
        rst_d2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_pix_div2();
        test_mid_reset();
        test_polarity();
        test_random_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
